// File: rtl/arduino_uart_tx_buffer.sv
// 8N1 UART transmitter with a small valid/ready FIFO in front of it.
// Words are queued, popped one at a time in IDLE, and shifted out LSB-first.
module arduino_uart_tx_buffer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk_50,
   input  logic                                 reset,
   input  logic [DATA_BITS-1:0]                 tx_data,
   input  logic                                 tx_valid,
   output logic                                 tx_ready,
   output logic                                 arduino_output,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int KW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;

   logic [1:0]           state_q, state_d;
   logic [KW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q;
   logic                 line_q, line_d;

   logic                 push;
   logic                 pop;
   logic                 shift_en;
   logic                 bit_done;

   // Ready comes only from the registered count, never from tx_valid.
   assign tx_ready       = (count_q != CW'(FIFO_DEPTH));
   assign push           = tx_valid && tx_ready;
   assign bit_done       = (clk_cnt_q == KW'(CLKS_PER_BIT - 1));
   assign arduino_output = line_q;
   assign busy           = (state_q != S_IDLE);
   assign fifo_count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // The line value is derived from the current state and registered,
   // so it lags the state by one cycle and never glitches.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      line_d    = 1'b1;
      pop       = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               state_d   = S_START;
               clk_cnt_d = '0;
            end
         end
         S_START: begin
            line_d = 1'b0;
            if (bit_done) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + KW'(1);
            end
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (bit_done) begin
               clk_cnt_d = '0;
               shift_en  = 1'b1;
               if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + KW'(1);
            end
         end
         S_STOP: begin
            line_d = 1'b1;
            if (bit_done) begin
               clk_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + KW'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            line_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         line_q    <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         line_q    <= line_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage and the shift register carry no reset; stale contents are
   // unreachable once the pointers and count are cleared.
   always_ff @(posedge clk_50) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
      if (pop) begin
         shift_q <= mem_q[rd_ptr_q];
      end else if (shift_en) begin
         shift_q <= shift_q >> 1;
      end
   end

endmodule

// File: tb/tb_arduino_uart_tx_buffer.sv
// Bench for arduino_uart_tx_buffer: a cycle-level frame model predicts line,
// busy, ready and count; a second instance checks the default baud timing.
module tb_arduino_uart_tx_buffer;

   localparam int CPB     = 4;
   localparam int DEPTH   = 4;
   localparam int DB      = 8;
   localparam int FRAME   = (DB + 2) * CPB;
   localparam int CPB_DEF = 434;

   logic       clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       arduino_output;
   logic       busy;
   logic [2:0] fifo_count;

   logic       def_reset = 1'b1;
   logic [7:0] def_tx_data = 8'h00;
   logic       def_tx_valid = 1'b0;
   logic       def_tx_ready;
   logic       def_line;
   logic       def_busy;
   logic [2:0] def_fifo_count;

   arduino_uart_tx_buffer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_50(clk_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .arduino_output(arduino_output), .busy(busy),
      .fifo_count(fifo_count)
   );

   arduino_uart_tx_buffer dut_def (
      .clk_50(clk_50), .reset(def_reset), .tx_data(def_tx_data), .tx_valid(def_tx_valid),
      .tx_ready(def_tx_ready), .arduino_output(def_line), .busy(def_busy),
      .fifo_count(def_fifo_count)
   );

   int checks = 0;
   int errors = 0;

   // Model: words waiting, the word currently framed, and when it was popped.
   int edge_n    = 0;
   int q[$];
   int cur_byte  = 0;
   int pop_edge  = -1;
   int free_edge = 0;

   function automatic logic exp_line();
      int o;
      int bp;
      if (pop_edge < 0) return 1'b1;
      o = edge_n - 1 - pop_edge;
      if (o < 0 || o >= FRAME) return 1'b1;
      bp = o / CPB;
      if (bp == 0) return 1'b0;
      if (bp == DB + 1) return 1'b1;
      return cur_byte[bp-1];
   endfunction

   function automatic logic exp_busy();
      return (pop_edge >= 0) && (edge_n >= pop_edge) && (edge_n < pop_edge + FRAME);
   endfunction

   function automatic logic model_idle();
      return (q.size() == 0) && !exp_busy() && (exp_line() == 1'b1);
   endfunction

   function automatic logic frame_bit55(input int t);
      int b;
      logic [7:0] v;
      v = 8'h55;
      b = t / CPB_DEF;
      if (b == 0) return 1'b0;
      if (b == DB + 1) return 1'b1;
      return v[b-1];
   endfunction

   // One clock: drive inputs, advance the model by the rules, sample at +1.
   task automatic tick(input logic rst, input logic v, input logic [7:0] d, output logic acc);
      int k;
      logic p;
      reset    = rst;
      tx_valid = v;
      tx_data  = d;
      k   = edge_n + 1;
      acc = !rst && v && (q.size() != DEPTH);
      p   = !rst && (q.size() > 0) && (k >= free_edge);
      @(posedge clk_50);
      #1;
      edge_n = k;
      if (rst) begin
         q.delete();
         pop_edge  = -1;
         free_edge = k + 1;
      end else begin
         if (p) begin
            cur_byte  = q.pop_front();
            pop_edge  = k;
            free_edge = k + FRAME + 1;
         end
         if (acc) q.push_back(int'(d));
      end
   endtask

   task automatic test_reset();
      logic acc;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 8'h00, acc);
         checks += 4;
         if (arduino_output !== 1'b1) begin errors++; $display("FAIL reset_line cyc=%0d got=%b want=1", i, arduino_output); end
         if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b want=1", i, tx_ready); end
         if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, busy); end
         if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count cyc=%0d got=%0d want=0", i, fifo_count); end
      end
      tick(1'b0, 1'b0, 8'h00, acc);
      $display("test_reset done");
   endtask

   task automatic test_single_byte();
      logic acc;
      int push_edge;
      int start_edge;
      int busy_cycles;
      tick(1'b0, 1'b1, 8'hA5, acc);
      push_edge   = edge_n;
      start_edge  = -1;
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < FRAME + 8; i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 3;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL single_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
         if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy edge=%0d got=%b want=%b", edge_n, busy, exp_busy()); end
         if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL single_count edge=%0d got=%0d want=%0d", edge_n, fifo_count, q.size()); end
         if (busy === 1'b1) busy_cycles++;
         if (arduino_output === 1'b0 && start_edge < 0) start_edge = edge_n;
      end
      checks += 2;
      if (busy_cycles != FRAME) begin errors++; $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, FRAME); end
      if (start_edge - push_edge != 2) begin errors++; $display("FAIL single_start_latency got=%0d want=2", start_edge - push_edge); end
      $display("test_single_byte A5 busy_cycles=%0d latency=%0d", busy_cycles, start_edge - push_edge);
   endtask

   task automatic test_fill_full();
      logic acc;
      int idx;
      int rises[$];
      logic prev_busy;
      logic saw_full;
      idx       = 1;
      prev_busy = busy;
      saw_full  = 1'b0;
      for (int i = 0; i < 600 && !(idx > 6 && model_idle()); i++) begin
         tick(1'b0, (idx <= 6), 8'(idx), acc);
         if (acc) idx++;
         checks += 4;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL fill_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
         if (busy !== exp_busy()) begin errors++; $display("FAIL fill_busy edge=%0d got=%b want=%b", edge_n, busy, exp_busy()); end
         if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL fill_count edge=%0d got=%0d want=%0d", edge_n, fifo_count, q.size()); end
         if (tx_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL fill_ready edge=%0d got=%b want=%b", edge_n, tx_ready, q.size() != DEPTH); end
         if (!saw_full && idx == 6) begin
            saw_full = 1'b1;
            checks += 2;
            if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_full_count got=%0d want=4", fifo_count); end
            if (tx_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b want=0", tx_ready); end
         end
         if (busy === 1'b1 && prev_busy !== 1'b1) rises.push_back(edge_n);
         prev_busy = busy;
      end
      checks += 1;
      if (rises.size() != 6) begin errors++; $display("FAIL fill_frames got=%0d want=6", rises.size()); end
      for (int j = 1; j < rises.size(); j++) begin
         checks += 1;
         if (rises[j] - rises[j-1] != FRAME + 1) begin errors++; $display("FAIL fill_spacing frame=%0d got=%0d want=%0d", j, rises[j] - rises[j-1], FRAME + 1); end
      end
      $display("test_fill_full frames=%0d", rises.size());
   endtask

   task automatic test_simul_push_pop();
      logic acc;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), acc);
      for (int i = 0; i < 100 && (edge_n + 1 != free_edge); i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 1;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL simul_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
      end
      checks += 1;
      if (edge_n + 1 != free_edge) begin errors++; $display("FAIL simul_wait_timeout edge=%0d want=%0d", edge_n + 1, free_edge); end
      tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), acc);
      checks += 2;
      if (fifo_count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d want=2", fifo_count); end
      if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy got=%b want=1", busy); end
      for (int i = 0; i < 400 && !model_idle(); i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 2;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL simul_drain_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
         if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL simul_drain_count edge=%0d got=%0d want=%0d", edge_n, fifo_count, q.size()); end
      end
      $display("test_simul_push_pop done");
   endtask

   task automatic test_reset_mid_frame();
      logic acc;
      tick(1'b0, 1'b1, 8'h00, acc);
      tick(1'b0, 1'b1, 8'hFF, acc);
      // Data bit 3 occupies frame offsets 4*CPB .. 5*CPB-1.
      for (int i = 0; i < 60 && (edge_n - 1 - pop_edge != 4 * CPB + 1); i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 1;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL midrst_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
      end
      tick(1'b1, 1'b0, 8'h00, acc);
      checks += 3;
      if (arduino_output !== 1'b1) begin errors++; $display("FAIL midrst_line_after got=%b want=1", arduino_output); end
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d want=0", fifo_count); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 2;
         if (arduino_output !== 1'b1) begin errors++; $display("FAIL midrst_quiet_line edge=%0d got=%b want=1", edge_n, arduino_output); end
         if (busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet_busy edge=%0d got=%b want=0", edge_n, busy); end
      end
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_random();
      logic acc;
      logic rst;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         tick(rst, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), acc);
         checks += 4;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL rand_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
         if (busy !== exp_busy()) begin errors++; $display("FAIL rand_busy edge=%0d got=%b want=%b", edge_n, busy, exp_busy()); end
         if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL rand_count edge=%0d got=%0d want=%0d", edge_n, fifo_count, q.size()); end
         if (tx_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rand_ready edge=%0d got=%b want=%b", edge_n, tx_ready, q.size() != DEPTH); end
      end
      for (int i = 0; i < 400 && !model_idle(); i++) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         checks += 1;
         if (arduino_output !== exp_line()) begin errors++; $display("FAIL rand_drain_line edge=%0d got=%b want=%b", edge_n, arduino_output, exp_line()); end
      end
      $display("test_random done");
   endtask

   task automatic test_baud_default();
      logic acc;
      int busy_cycles;
      int wait_cycles;
      int bad_bits;
      def_reset = 1'b0;
      tick(1'b0, 1'b0, 8'h00, acc);
      def_tx_valid = 1'b1;
      def_tx_data  = 8'h55;
      tick(1'b0, 1'b0, 8'h00, acc);
      def_tx_valid = 1'b0;
      busy_cycles = (def_busy === 1'b1) ? 1 : 0;
      wait_cycles = 0;
      while (def_line !== 1'b0 && wait_cycles < 10) begin
         tick(1'b0, 1'b0, 8'h00, acc);
         wait_cycles++;
         if (def_busy === 1'b1) busy_cycles++;
      end
      checks += 1;
      if (wait_cycles != 2) begin errors++; $display("FAIL baud_start_latency got=%0d want=2", wait_cycles); end
      bad_bits = 0;
      for (int t = 0; t < 10 * CPB_DEF; t++) begin
         checks += 1;
         if (def_line !== frame_bit55(t)) begin
            errors++;
            bad_bits++;
            if (bad_bits <= 10) $display("FAIL baud_line t=%0d got=%b want=%b", t, def_line, frame_bit55(t));
         end
         tick(1'b0, 1'b0, 8'h00, acc);
         if (def_busy === 1'b1) busy_cycles++;
      end
      for (int i = 0; i < 4; i++) begin
         checks += 1;
         if (def_line !== 1'b1) begin errors++; $display("FAIL baud_idle_line got=%b want=1", def_line); end
         tick(1'b0, 1'b0, 8'h00, acc);
         if (def_busy === 1'b1) busy_cycles++;
      end
      checks += 1;
      if (busy_cycles != 10 * CPB_DEF) begin errors++; $display("FAIL baud_frame_len got=%0d want=%0d", busy_cycles, 10 * CPB_DEF); end
      $display("test_baud_default frame_cycles=%0d", busy_cycles);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fill_full();
      test_simul_push_pop();
      test_reset_mid_frame();
      test_random();
      test_baud_default();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
